// File: rtl/asym_ram_seq_pkg.sv
// Shared types and default geometry for the asymmetric buffer-RAM sequencer.
// Default geometry is a 32-bit write port and a 512-bit read port (16 narrow words per wide word).
package asym_ram_seq_pkg;

  localparam int DATAWIDTHA_DEF = 32;
  localparam int RATIO          = 16;
  localparam int LOG2RATIO      = $clog2(RATIO);
  localparam int DATAWIDTHB_DEF = DATAWIDTHA_DEF * RATIO;
  localparam int ADDRWIDTHB_DEF = 10;
  localparam int ADDRWIDTHA_DEF = ADDRWIDTHB_DEF + LOG2RATIO;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/asym_ram_seq_ctrl.sv
// Load/play sequencer for a narrow-write / wide-read simple-dual-port RAM.
// Port A is filled from a valid/ready stream; port B is swept in passes, optionally looping.
module asym_ram_seq_ctrl
  import asym_ram_seq_pkg::*;
#(
  parameter int DATAWIDTHA = DATAWIDTHA_DEF,
  parameter int ADDRWIDTHA = ADDRWIDTHA_DEF,
  parameter int DATAWIDTHB = DATAWIDTHB_DEF,
  parameter int ADDRWIDTHB = ADDRWIDTHB_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_start,
  input  logic [DATAWIDTHA-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  play_start,
  input  logic [ADDRWIDTHB-1:0] play_len,
  input  logic                  play_loop,
  input  logic                  play_stop,
  output logic                  ram_enaA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [DATAWIDTHA-1:0] ram_diA,
  output logic                  ram_enaB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [DATAWIDTHB-1:0] ram_doB,
  output logic [DATAWIDTHB-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDRWIDTHA-1:0] WPTR_ONE = ADDRWIDTHA'(1);
  localparam logic [ADDRWIDTHB-1:0] RPTR_ONE = ADDRWIDTHB'(1);

  seq_state_e            state_q, state_d;
  logic [ADDRWIDTHA-1:0] wptr_q, wptr_d;
  logic [ADDRWIDTHB-1:0] rptr_q, rptr_d;
  logic [ADDRWIDTHB-1:0] len_q, len_d;
  logic                  loop_q, loop_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  pdone_p1_q, pdone_p1_d;

  logic                  accept;
  logic                  load_end;
  logic                  issue;
  logic                  pass_end;
  logic [ADDRWIDTHB-1:0] last_addr;

  // len_q = 0 encodes a full 2^ADDRWIDTHB pass: 0 - 1 wraps to the last address.
  assign last_addr = len_q - RPTR_ONE;

  assign wr_ready = (state_q == ST_LOAD);
  assign accept   = wr_ready & wr_valid;
  assign load_end = accept & (wr_last | (wptr_q == '1));
  assign issue    = (state_q == ST_PLAY) & ~play_stop;
  assign pass_end = issue & (rptr_q == last_addr);

  assign ram_enaA  = accept;
  assign ram_weA   = accept;
  assign ram_addrA = wptr_q;
  assign ram_diA   = accept ? wr_data : '0;
  assign ram_enaB  = issue;
  assign ram_addrB = rptr_q;

  // dout is forced to zero between valid beats so the block presents all-zero outputs out of reset.
  assign dout       = vld_p1_q ? ram_doB : '0;
  assign dout_valid = vld_p1_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = load_end | pdone_p1_q;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    len_d      = len_q;
    loop_d     = loop_q;
    vld_p1_d   = issue;
    pdone_p1_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
        end else if (play_start) begin
          state_d = ST_PLAY;
          rptr_d  = '0;
          len_d   = play_len;
          loop_d  = play_loop;
        end
      end
      ST_LOAD: begin
        if (load_end) begin
          state_d = ST_IDLE;
          wptr_d  = '0;
        end else if (accept) begin
          wptr_d = wptr_q + WPTR_ONE;
        end
      end
      ST_PLAY: begin
        if (play_stop) begin
          state_d = ST_IDLE;
          rptr_d  = '0;
        end else if (pass_end) begin
          rptr_d = '0;
          if (!loop_q) begin
            state_d    = ST_IDLE;
            pdone_p1_d = 1'b1;
          end
        end else begin
          rptr_d = rptr_q + RPTR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- registered state, pointers and the one-cycle read-latency stage ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      pdone_p1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      vld_p1_q   <= vld_p1_d;
      pdone_p1_q <= pdone_p1_d;
    end
  end

endmodule

// File: tb/tb_asym_ram_seq_ctrl.sv
// Bench for asym_ram_seq_ctrl: behavioural asymmetric RAM, table-driven play scenarios,
// hand-written corner sequences and randomized load/play traffic against a reference model.
module tb_asym_ram_seq_ctrl;

  localparam int DWA = 32;
  localparam int AWA = 14;
  localparam int DWB = 512;
  localparam int AWB = 10;
  localparam int R   = DWB / DWA;
  localparam int NA  = 1 << AWA;
  localparam int NB  = 1 << AWB;

  logic           clk = 1'b0;
  logic           rstn;
  logic           load_start;
  logic [DWA-1:0] wr_data;
  logic           wr_valid;
  logic           wr_last;
  logic           wr_ready;
  logic           play_start;
  logic [AWB-1:0] play_len;
  logic           play_loop;
  logic           play_stop;
  logic           ram_enaA;
  logic           ram_weA;
  logic [AWA-1:0] ram_addrA;
  logic [DWA-1:0] ram_diA;
  logic           ram_enaB;
  logic [AWB-1:0] ram_addrB;
  logic [DWB-1:0] ram_doB;
  logic [DWB-1:0] dout;
  logic           dout_valid;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  asym_ram_seq_ctrl #(
    .DATAWIDTHA(DWA), .ADDRWIDTHA(AWA), .DATAWIDTHB(DWB), .ADDRWIDTHB(AWB)
  ) dut (
    .clk(clk), .rstn(rstn),
    .load_start(load_start), .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .play_start(play_start), .play_len(play_len), .play_loop(play_loop), .play_stop(play_stop),
    .ram_enaA(ram_enaA), .ram_weA(ram_weA), .ram_addrA(ram_addrA), .ram_diA(ram_diA),
    .ram_enaB(ram_enaB), .ram_addrB(ram_addrB), .ram_doB(ram_doB),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  // Behavioural RAM: narrow write port, wide registered read (lowest narrow address in lane 0).
  logic [DWA-1:0] ram_mem [0:NA-1];
  always @(posedge clk) begin
    if (ram_enaA && ram_weA) ram_mem[ram_addrA] <= ram_diA;
    if (ram_enaB)
      for (int k = 0; k < R; k++) ram_doB[k*DWA +: DWA] <= ram_mem[int'(ram_addrB) * R + k];
  end

  // Reference contents: what the bench itself sent, indexed by stream position.
  logic [DWA-1:0] ref_mem [0:NA-1];

  int nvec = 0;
  int nmis = 0;

  function automatic logic [DWB-1:0] ref_wide(input int a);
    logic [DWB-1:0] w;
    for (int k = 0; k < R; k++) w[k*DWA +: DWA] = ref_mem[a * R + k];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [DWB-1:0] got, input logic [DWB-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic idle_inputs();
    load_start = 0; wr_data = '0; wr_valid = 0; wr_last = 0;
    play_start = 0; play_len = '0; play_loop = 0; play_stop = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_enaA"}, ram_enaA, 0);
    chk({tag, "_weA"}, ram_weA, 0);
    chk({tag, "_addrA"}, ram_addrA, 0);
    chk({tag, "_diA"}, ram_diA, 0);
    chk({tag, "_enaB"}, ram_enaB, 0);
    chk({tag, "_addrB"}, ram_addrB, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset();
    rstn = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rstn = 1;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1;
    #1;
    chk("ld_start_ready", wr_ready, 0);
    chk("ld_start_busy", busy, 0);
  endtask

  // Streams n words; the load must finish on word n-1 (wr_last or top address).
  task automatic feed(input int n, input bit use_last, input bit gaps, input bit seq_data);
    int idx = 0;
    int cyc = 0;
    bit v;
    logic [DWA-1:0] d;
    while (idx < n && cyc < n * 8 + 20) begin
      @(negedge clk);
      load_start = 0;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = seq_data ? DWA'(idx) : DWA'($urandom);
      wr_valid = v;
      wr_data  = d;
      wr_last  = v ? (use_last && idx == n - 1) : 1'($urandom_range(0, 1));
      #1;
      chk("ld_ready", wr_ready, 1);
      chk("ld_enaA", ram_enaA, v);
      chk("ld_enaB", ram_enaB, 0);
      if (v) begin
        chk("ld_weA", ram_weA, 1);
        chk("ld_addrA", ram_addrA, idx);
        chk("ld_diA", ram_diA, d);
        chk("ld_done", done, idx == n - 1);
        ref_mem[idx] = d;
        idx++;
      end else begin
        chk("ld_done_nobeat", done, 0);
      end
      cyc++;
    end
    if (idx < n) fail("ld_timeout");
    @(negedge clk);
    wr_valid = 0; wr_last = 0; wr_data = '0;
    #1;
    chk("ld_ready_after", wr_ready, 0);
    chk("ld_busy_after", busy, 0);
  endtask

  // Plays one programmed sequence; expectations come from the caller (table or model).
  task automatic run_play(input string nm, input int len, input bit loop, input int stop_after,
                          input int exp_issues, input int exp_done);
    int leff;
    int issued = 0;
    int valids = 0;
    int dones = 0;
    int cyc = 0;
    int a;
    bit stop_now;
    bit ended = 0;
    int expq[$];
    leff = (len == 0) ? NB : len;
    @(negedge clk);
    play_start = 1; play_len = AWB'(len); play_loop = loop;
    #1;
    chk({nm, "_idle_enaB"}, ram_enaB, 0);
    while (cyc < 3 * NB) begin
      @(negedge clk);
      play_start = 0;
      play_len = AWB'($urandom);
      play_loop = ~loop;
      stop_now = (stop_after != 0) && (issued == stop_after) && busy;
      play_stop = stop_now;
      #1;
      if (stop_now) chk({nm, "_stop_no_issue"}, ram_enaB, 0);
      if (ram_enaB) begin
        chk({nm, "_addrB"}, ram_addrB, issued % leff);
        expq.push_back(issued % leff);
        issued++;
      end
      if (dout_valid) begin
        if (expq.size() == 0) begin
          chk({nm, "_spurious_valid"}, dout_valid, 0);
        end else begin
          a = expq.pop_front();
          chk({nm, "_dout"}, dout, ref_wide(a));
        end
        valids++;
      end
      if (done) begin
        dones++;
        chk({nm, "_done_with_valid"}, dout_valid, 1);
        chk({nm, "_done_busy"}, busy, 0);
      end
      cyc++;
      if (!busy && !dout_valid && !ram_enaB) begin
        ended = 1;
        break;
      end
    end
    play_stop = 0;
    if (!ended) fail({nm, "_timeout"});
    chk({nm, "_issues"}, issued, exp_issues);
    chk({nm, "_valids"}, valids, exp_issues);
    chk({nm, "_dones"}, dones, exp_done);
  endtask

  typedef struct {
    string nm;
    int    len;
    bit    loop;
    int    stop_after;
    int    exp_issues;
    int    exp_done;
  } play_vec_t;

  play_vec_t tbl[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit hit;
    tbl[0] = '{"len2",        2,    1'b0, 0, 2,    1};
    tbl[1] = '{"len3_loop",   3,    1'b1, 7, 7,    0};
    tbl[2] = '{"len0_full",   0,    1'b0, 0, 1024, 1};
    tbl[3] = '{"len5_stop3",  5,    1'b0, 3, 3,    0};
    tbl[4] = '{"len1_loop",   1,    1'b1, 5, 5,    0};
    tbl[5] = '{"len1023",     1023, 1'b0, 0, 1023, 1};
    tbl[6] = '{"len7_stop7",  7,    1'b0, 7, 7,    1};

    do_reset();

    // Load 0..31 terminated by wr_last.
    start_load();
    feed(32, 1'b1, 1'b0, 1'b1);

    // Two-word play, cycle by cycle.
    @(negedge clk);
    play_start = 1; play_len = 2; play_loop = 0;
    #1;
    chk("p2_c0_enaB", ram_enaB, 0);
    @(negedge clk);
    play_start = 0;
    #1;
    chk("p2_c1_enaB", ram_enaB, 1);
    chk("p2_c1_addrB", ram_addrB, 0);
    chk("p2_c1_valid", dout_valid, 0);
    chk("p2_c1_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("p2_c2_enaB", ram_enaB, 1);
    chk("p2_c2_addrB", ram_addrB, 1);
    chk("p2_c2_valid", dout_valid, 1);
    chk("p2_c2_lane0", dout[31:0], 0);
    chk("p2_c2_done", done, 0);
    @(negedge clk);
    #1;
    chk("p2_c3_enaB", ram_enaB, 0);
    chk("p2_c3_busy", busy, 0);
    chk("p2_c3_valid", dout_valid, 1);
    chk("p2_c3_lane0", dout[31:0], 16);
    chk("p2_c3_lane1", dout[63:32], 17);
    chk("p2_c3_done", done, 1);
    @(negedge clk);
    #1;
    chk("p2_c4_valid", dout_valid, 0);
    chk("p2_c4_done", done, 0);

    // Full-depth load with no wr_last: ends on the top address.
    start_load();
    feed(NA, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++)
      run_play(tbl[i].nm, tbl[i].len, tbl[i].loop, tbl[i].stop_after,
               tbl[i].exp_issues, tbl[i].exp_done);

    // load_start and play_start together: LOAD wins; play_start inside LOAD is ignored.
    @(negedge clk);
    load_start = 1; play_start = 1; play_len = 4;
    #1;
    chk("both_busy_before", busy, 0);
    @(negedge clk);
    load_start = 0;
    #1;
    chk("both_in_load", wr_ready, 1);
    chk("both_no_read", ram_enaB, 0);
    feed(4, 1'b1, 1'b1, 1'b0);
    play_start = 0;
    @(negedge clk);
    #1;
    chk("both_play_ignored", busy, 0);

    // Reset while PLAY is issuing address 5.
    @(negedge clk);
    play_start = 1; play_len = 20; play_loop = 0;
    #1;
    cnt = 0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      play_start = 0;
      #1;
      if (ram_enaB) begin
        chk("rst_addrB", ram_addrB, cnt);
        if (ram_addrB == 5) begin
          rstn = 0;
          hit = 1;
        end
        cnt++;
      end
    end
    if (!hit) fail("rst_reach_addr5");
    @(negedge clk);
    #1;
    check_zero("rst_mid_play");
    @(negedge clk);
    #1;
    chk("rst_no_late_valid", dout_valid, 0);
    rstn = 1;

    // Randomized traffic against the reference model.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        start_load();
        feed($urandom_range(1, 40), 1'b1, 1'b1, 1'b0);
      end else begin
        int len, stop_after, leff, exp_issues, exp_done;
        bit loop;
        len = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 40);
        leff = (len == 0) ? NB : len;
        loop = 1'($urandom_range(0, 1));
        if (loop) stop_after = $urandom_range(1, 90);
        else stop_after = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : 0;
        if (loop) begin
          exp_issues = stop_after;
          exp_done = 0;
        end else if (stop_after != 0 && stop_after < leff) begin
          exp_issues = stop_after;
          exp_done = 0;
        end else begin
          exp_issues = leff;
          exp_done = 1;
        end
        run_play("rnd", len, loop, stop_after, exp_issues, exp_done);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
